lc3_fetch: RTL and testbench
============================

LC3_FETCH -- requirements
Module: lc3_fetch

Interface
REQ-001 Parameter: RESET_PC, 16'h3000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instrmem_rd  output  1  instruction-memory read request.
REQ-005 pc  output  16  address of the outstanding fetch; stable while instrmem_rd=1.
REQ-006 Instr_dout  input  16  instruction word from memory; valid only when complete_instr=1.
REQ-007 complete_instr  input  1  memory completes the outstanding read this cycle.
REQ-008 stall  input  1  decode not ready; ir/ir_valid/npc held when ir_valid=1.
REQ-009 br_taken  input  1  redirect request from execute/writeback.
REQ-010 taddr  input  16  redirect target; sampled when br_taken=1.
REQ-011 ir  output  16  fetched instruction presented to decode.
REQ-012 ir_valid  output  1  ir holds a valid instruction.
REQ-013 npc  output  16  address of ir + 1.

Function
REQ-014 FSM states: IDLE, REQ, HOLD, FLUSH; instrmem_rd=1 exactly in REQ and FLUSH.
REQ-015 IDLE: next cycle -> REQ unconditionally.
REQ-016 REQ: on complete_instr with output slot free (ir_valid=0 or stall=0): ir<=Instr_dout, ir_valid<=1, npc<=pc+1, pc<=pc+1, stay REQ (back-to-back fetch).
REQ-017 REQ: on complete_instr with ir_valid=1 and stall=1: word and its npc captured in skid entry, pc<=pc+1, -> HOLD.
REQ-018 HOLD: instrmem_rd=0; when stall=0, skid moves to ir/npc (ir_valid stays 1), -> REQ next cycle.
REQ-019 ir_valid drops to 0 when decode consumes (ir_valid=1, stall=0) and no new word arrives that cycle.
REQ-020 Handover: at most one instruction consumed per cycle; instructions delivered in address order, none duplicated or dropped absent redirect.
REQ-021 br_taken in REQ without complete_instr: ir_valid<=0, skid cleared, target saved, -> FLUSH; pc output unchanged.
REQ-022 FLUSH: on complete_instr, data discarded, pc<=saved target, -> REQ; br_taken in FLUSH overwrites saved target (latest wins).
REQ-023 br_taken with complete_instr in same REQ cycle: data discarded, pc<=taddr, ir_valid<=0, stay REQ.
REQ-024 br_taken in IDLE or HOLD: pc<=taddr, ir_valid<=0, skid cleared, -> REQ.
REQ-025 br_taken overrides stall; redirect always flushes ir.
REQ-026 pc and npc arithmetic modulo 2^16: 16'hFFFF+1 = 16'h0000.
REQ-027 complete_instr outside REQ/FLUSH is ignored.

Reset
REQ-028 reset=1: state<=IDLE, pc<=RESET_PC, instrmem_rd=0, ir<=0, ir_valid<=0, npc<=0, skid cleared, saved target<=0.
REQ-029 Reset mid-fetch abandons the outstanding read; a complete_instr in the first post-reset cycle is ignored.
REQ-030 Reset has priority over br_taken, stall, complete_instr.

Structure
REQ-031 Shared package lc3_pkg holds fetch-state enum (IDLE/REQ/HOLD/FLUSH), LC3_WORD_W=16, default RESET_PC=16'h3000.
REQ-032 One sub-module lc3_fetch_skid: single-entry buffer (word+npc, valid, load, drain, clear); FSM and pc logic remain in lc3_fetch.

Verification
REQ-033 Reset 2 cycles, memory completes every REQ cycle, stall=0 -> pc 3000,3001,3002; ir_valid first rises 2 cycles after reset release (IDLE, REQ); npc=3001 with first word.
REQ-034 ir_valid=1, stall=1, complete_instr with 16'h1234 -> HOLD, instrmem_rd=0; stall released -> ir=16'h1234 next cycle, no loss/duplication.
REQ-035 REQ at pc=3005, br_taken taddr=3100, complete_instr 3 cycles later -> data discarded, ir_valid=0, next fetch pc=3100.
REQ-036 br_taken taddr=3200 and complete_instr same cycle -> word dropped, next pc=3200, ir_valid=0.
REQ-037 RESET_PC=16'hFFFF -> first npc=16'h0000, second fetch pc=16'h0000.
REQ-038 reset asserted with fetch outstanding and ir_valid=1 -> all outputs at reset values next cycle; stray complete_instr ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared fetch-state enum, word width and default reset address
package lc3_pkg;
  localparam int LC3_WORD_W = 16;
  localparam logic [LC3_WORD_W-1:0] RESET_PC_DEFAULT = 16'h3000;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} fetch_state_t;
  function automatic logic [LC3_WORD_W-1:0] word_inc(input logic [LC3_WORD_W-1:0] a);
    return a + 1'b1;
  endfunction
endpackage

// File: rtl/lc3_fetch_if.sv
// lc3_fetch_if: instruction-memory read bus between fetch (master) and memory (slave)
interface lc3_fetch_if;
  logic instrmem_rd;
  logic [lc3_pkg::LC3_WORD_W-1:0] pc;
  logic [lc3_pkg::LC3_WORD_W-1:0] Instr_dout;
  logic complete_instr;
  modport master(output instrmem_rd, pc, input Instr_dout, complete_instr);
  modport slave(input instrmem_rd, pc, output Instr_dout, complete_instr);
endinterface

// File: rtl/lc3_fetch_skid.sv
// lc3_fetch_skid: single-entry word+npc buffer; clear beats load beats drain
module lc3_fetch_skid
  import lc3_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  drain,
  input  logic                  clear,
  input  logic [LC3_WORD_W-1:0] din_word,
  input  logic [LC3_WORD_W-1:0] din_npc,
  output logic                  valid,
  output logic [LC3_WORD_W-1:0] word,
  output logic [LC3_WORD_W-1:0] npc
);
  always_ff @(posedge clk)
    if (reset || clear) begin
      valid <= 1'b0;
      word  <= '0;
      npc   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= din_word;
      npc   <= din_npc;
    end else if (drain) valid <= 1'b0;
endmodule

// File: rtl/lc3_fetch.sv
// lc3_fetch: LC-3 instruction fetch with one-deep skid, redirect flush and modulo-2^16 pc
module lc3_fetch
  import lc3_pkg::*;
#(
  parameter logic [LC3_WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  lc3_fetch_if.master           mem,
  input  logic                  stall,
  input  logic                  br_taken,
  input  logic [LC3_WORD_W-1:0] taddr,
  output logic [LC3_WORD_W-1:0] ir,
  output logic                  ir_valid,
  output logic [LC3_WORD_W-1:0] npc
);
  fetch_state_t st, st_n;
  logic [LC3_WORD_W-1:0] pc_q, pc_n, ir_n, npc_n, tgt, tgt_n, sk_word, sk_npc;
  logic irv_n, sk_load, sk_drain, sk_clear, sk_valid;
  assign mem.pc = pc_q;
  assign mem.instrmem_rd = st == REQ || st == FLUSH;
  lc3_fetch_skid u_skid (
    .clk(clk), .reset(reset), .load(sk_load), .drain(sk_drain), .clear(sk_clear),
    .din_word(mem.Instr_dout), .din_npc(word_inc(pc_q)),
    .valid(sk_valid), .word(sk_word), .npc(sk_npc)
  );
  always_comb begin
    st_n = st;
    pc_n = pc_q;
    ir_n = ir;
    irv_n = ir_valid && stall;
    npc_n = npc;
    tgt_n = tgt;
    sk_load = 1'b0;
    sk_drain = 1'b0;
    sk_clear = 1'b0;
    case (st)
      IDLE: begin
        st_n = REQ;
        if (br_taken) begin
          pc_n = taddr;
          irv_n = 1'b0;
          sk_clear = 1'b1;
        end
      end
      REQ: begin
        if (br_taken) begin
          irv_n = 1'b0;
          sk_clear = 1'b1;
          pc_n = mem.complete_instr ? taddr : pc_q;
          tgt_n = mem.complete_instr ? tgt : taddr;
          st_n = mem.complete_instr ? REQ : FLUSH;
        end else if (mem.complete_instr) begin
          pc_n = word_inc(pc_q);
          // occupied slot that decode is not taking: park the word in the skid
          if (ir_valid && stall) begin
            sk_load = 1'b1;
            st_n = HOLD;
          end else begin
            ir_n = mem.Instr_dout;
            irv_n = 1'b1;
            npc_n = pc_n;
          end
        end
      end
      HOLD: begin
        if (br_taken) begin
          pc_n = taddr;
          irv_n = 1'b0;
          sk_clear = 1'b1;
          st_n = REQ;
        end else if (!stall && sk_valid) begin
          ir_n = sk_word;
          npc_n = sk_npc;
          irv_n = 1'b1;
          sk_drain = 1'b1;
          st_n = REQ;
        end
      end
      FLUSH: begin
        tgt_n = br_taken ? taddr : tgt;
        pc_n = mem.complete_instr ? tgt_n : pc_q;
        st_n = mem.complete_instr ? REQ : FLUSH;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      pc_q <= RESET_PC;
      ir <= '0;
      ir_valid <= 1'b0;
      npc <= '0;
      tgt <= '0;
    end else begin
      st <= st_n;
      pc_q <= pc_n;
      ir <= ir_n;
      ir_valid <= irv_n;
      npc <= npc_n;
      tgt <= tgt_n;
    end
endmodule

// File: tb/tb_lc3_fetch.sv
// tb_lc3_fetch: directed fetch sequence with a word/npc scoreboard popped on each decode handover
module tb_lc3_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic br_taken = 1'b0;
  logic [15:0] taddr = '0;
  logic [15:0] ir, npc, ir2, npc2;
  logic ir_valid, ir_valid2;
  int checks = 0;
  int fails = 0;
  logic [31:0] sb[$];
  lc3_fetch_if m();
  lc3_fetch_if m2();
  lc3_fetch dut (
    .clk(clk), .reset(reset), .mem(m), .stall(stall), .br_taken(br_taken), .taddr(taddr),
    .ir(ir), .ir_valid(ir_valid), .npc(npc)
  );
  lc3_fetch #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .reset(reset), .mem(m2), .stall(stall), .br_taken(br_taken), .taddr(taddr),
    .ir(ir2), .ir_valid(ir_valid2), .npc(npc2)
  );
  assign m2.complete_instr = m2.instrmem_rd;
  assign m2.Instr_dout = m2.pc;
  always #5 clk = ~clk;
  function automatic logic [15:0] data_of(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [15:0] w, input logic [15:0] n);
    sb.push_back({w, n});
  endtask
  task automatic step(input logic c, input logic s, input logic b, input logic [15:0] t,
                      input logic [15:0] d);
    m.complete_instr = c;
    m.Instr_dout = d;
    stall = s;
    br_taken = b;
    taddr = t;
    if (!reset && ir_valid && !s && !b) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("handover", {ir, npc}, sb.pop_front());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic c, input logic s);
    step(c, s, 1'b0, 16'h0, data_of(m.pc));
  endtask
  initial begin
    m.complete_instr = 1'b0;
    m.Instr_dout = '0;
    go(0, 0);
    go(0, 0);
    chk("rst_rd", 32'(m.instrmem_rd), 32'd0);
    chk("rst_pc", 32'(m.pc), 32'h3000);
    chk("rst_ir", {ir, npc}, 32'h0);
    chk("rst_irv", 32'(ir_valid), 32'd0);
    reset = 1'b0;
    go(0, 0);
    chk("idle_to_req_rd", 32'(m.instrmem_rd), 32'd1);
    chk("idle_irv", 32'(ir_valid), 32'd0);
    chk("wrap_first_pc", 32'(m2.pc), 32'hFFFF);
    push(data_of(16'h3000), 16'h3001);
    go(1, 0);
    chk("first_irv", 32'(ir_valid), 32'd1);
    chk("first_word", {ir, npc}, {data_of(16'h3000), 16'h3001});
    chk("pc_3001", 32'(m.pc), 32'h3001);
    chk("wrap_npc", {ir2, npc2}, 32'hFFFF_0000);
    chk("wrap_pc", 32'(m2.pc), 32'h0000);
    push(data_of(16'h3001), 16'h3002);
    go(1, 0);
    chk("pc_3002", 32'(m.pc), 32'h3002);
    chk("wrap_pc2", 32'(m2.pc), 32'h0001);
    push(data_of(16'h3002), 16'h3003);
    go(1, 0);
    push(16'h1234, 16'h3004);
    step(1, 1, 0, 16'h0, 16'h1234);
    chk("hold_rd", 32'(m.instrmem_rd), 32'd0);
    chk("hold_ir_kept", {ir, npc}, {data_of(16'h3002), 16'h3003});
    go(0, 1);
    chk("hold_rd2", 32'(m.instrmem_rd), 32'd0);
    go(0, 0);
    chk("skid_out", {ir, npc}, 32'h1234_3004);
    chk("skid_irv", 32'(ir_valid), 32'd1);
    chk("after_hold_pc", 32'(m.pc), 32'h3004);
    chk("after_hold_rd", 32'(m.instrmem_rd), 32'd1);
    go(0, 0);
    chk("consume_drop", 32'(ir_valid), 32'd0);
    push(data_of(16'h3004), 16'h3005);
    go(1, 0);
    go(0, 0);
    step(0, 0, 1, 16'h3100, 16'h0);
    chk("flush_pc_kept", 32'(m.pc), 32'h3005);
    chk("flush_rd", 32'(m.instrmem_rd), 32'd1);
    go(0, 0);
    go(0, 0);
    chk("flush_wait_pc", 32'(m.pc), 32'h3005);
    step(1, 0, 0, 16'h0, 16'hDEAD);
    chk("flush_target", 32'(m.pc), 32'h3100);
    chk("flush_irv", 32'(ir_valid), 32'd0);
    push(data_of(16'h3100), 16'h3101);
    go(1, 0);
    go(0, 0);
    step(1, 0, 1, 16'h3200, 16'hBEEF);
    chk("br_cmp_pc", 32'(m.pc), 32'h3200);
    chk("br_cmp_irv", 32'(ir_valid), 32'd0);
    go(1, 0);
    go(1, 1);
    chk("hold2_rd", 32'(m.instrmem_rd), 32'd0);
    step(0, 1, 1, 16'h3300, 16'h0);
    chk("br_hold_pc", 32'(m.pc), 32'h3300);
    chk("br_hold_irv", 32'(ir_valid), 32'd0);
    chk("br_hold_rd", 32'(m.instrmem_rd), 32'd1);
    push(data_of(16'h3300), 16'h3301);
    go(1, 0);
    go(1, 0);
    reset = 1'b1;
    go(0, 0);
    chk("rst2_rd", 32'(m.instrmem_rd), 32'd0);
    chk("rst2_pc", 32'(m.pc), 32'h3000);
    chk("rst2_ir", {ir, npc}, 32'h0);
    chk("rst2_irv", 32'(ir_valid), 32'd0);
    reset = 1'b0;
    step(1, 0, 0, 16'h0, 16'hDEAD);
    chk("stray_pc", 32'(m.pc), 32'h3000);
    chk("stray_irv", 32'(ir_valid), 32'd0);
    push(data_of(16'h3000), 16'h3001);
    go(1, 0);
    go(0, 0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
